// File: rtl/run_length_logger.sv
// Measures s2 dwell runs from the X-detector (Z2 = stay, Z1 = exit), queues
// completed run lengths in a 2-deep buffer and keeps drop/error/total stats.
module run_length_logger #(
  parameter int W      = 8,
  parameter int DROP_W = 8,
  parameter int TOT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Yc,
  input  logic              Z1,
  input  logic              Z2,
  input  logic              run_ready,
  output logic              run_valid,
  output logic [W-1:0]      run_len,
  output logic              run_sat,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              proto_err,
  output logic [TOT_W-1:0]  total_runs
);

  localparam logic [W-1:0]      LEN_MAX  = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
  localparam logic [TOT_W-1:0]  TOT_MAX  = '1;

  typedef struct packed {
    logic         sat;
    logic [W-1:0] len;
  } rec_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_e;

  buf_state_e        state_q, state_d;
  rec_t              head_q, head_d, tail_q, tail_d;
  logic [W-1:0]      acc_q, acc_d;
  logic              acc_sat_q, acc_sat_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              perr_q, perr_d;
  logic [TOT_W-1:0]  tot_q, tot_d;

  logic acc_at_max, push, pop, drop;
  rec_t new_rec;

  assign acc_at_max  = (acc_q == LEN_MAX);
  assign new_rec.len = acc_at_max ? LEN_MAX : acc_q + 1'b1;
  assign new_rec.sat = acc_sat_q | acc_at_max;
  assign push        = Z1;
  assign pop         = run_valid & run_ready;

  // Run accumulator and statistics; Z1 takes precedence over Z2.
  always_comb begin
    acc_d      = acc_q;
    acc_sat_d  = acc_sat_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    perr_d     = perr_q;
    tot_d      = tot_q;
    if (Z1) begin
      acc_d     = '0;
      acc_sat_d = 1'b0;
      if (tot_q != TOT_MAX) tot_d = tot_q + 1'b1;
    end else if (Z2) begin
      if (acc_at_max) acc_sat_d = 1'b1;
      else            acc_d     = acc_q + 1'b1;
    end
    if ((Z1 & Z2) | ((Z1 | Z2) & ~Yc)) perr_d = 1'b1;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != DROP_MAX) drop_d = drop_q + 1'b1;
    end
  end

  // Buffer FSM: the head register always holds the oldest record.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    drop    = 1'b0;
    unique case (state_q)
      EMPTY: if (push) begin
        state_d = ONE;
        head_d  = new_rec;
      end
      ONE: begin
        if (push && pop) head_d = new_rec;
        else if (push) begin
          state_d = FULL;
          tail_d  = new_rec;
        end else if (pop) state_d = EMPTY;
      end
      FULL: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = new_rec;
          else      state_d = ONE;
        end else if (push) drop = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      acc_q      <= '0;
      acc_sat_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      perr_q     <= 1'b0;
      tot_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      acc_q      <= acc_d;
      acc_sat_q  <= acc_sat_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      perr_q     <= perr_d;
      tot_q      <= tot_d;
    end
  end

  assign run_valid  = (state_q != EMPTY);
  assign run_len    = head_q.len;
  assign run_sat    = head_q.sat;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_q;
  assign proto_err  = perr_q;
  assign total_runs = tot_q;

endmodule

// File: tb/tb_run_length_logger.sv
// Bench for run_length_logger: directed vector table, hand-written corner
// sequences and randomized traffic, all against a queue-based reference model.
module tb_run_length_logger;

  logic        clk = 1'b0;
  logic        reset;
  logic        Yc, Z1, Z2, run_ready;
  logic        run_valid, run_sat, overflow, proto_err;
  logic [7:0]  run_len, drop_cnt;
  logic [15:0] total_runs;

  int checks = 0;
  int errors = 0;

  run_length_logger #(.W(8), .DROP_W(8), .TOT_W(16)) dut (
    .clk(clk), .reset(reset), .Yc(Yc), .Z1(Z1), .Z2(Z2), .run_ready(run_ready),
    .run_valid(run_valid), .run_len(run_len), .run_sat(run_sat),
    .overflow(overflow), .drop_cnt(drop_cnt), .proto_err(proto_err),
    .total_runs(total_runs)
  );

  always #5 clk = ~clk;

  // Reference model: unbounded run counter, records in a queue of max depth 2.
  typedef struct { int len; bit sat; } mrec_t;
  mrec_t m_q[$];
  int    m_cnt, m_drop, m_tot;
  bit    m_ovf, m_perr;

  typedef struct {
    bit yc, z1, z2, rdy;
    bit ev; int elen; bit esat; int etot; int edrop; bit eovf;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_cnt = 0; m_drop = 0; m_tot = 0; m_ovf = 0; m_perr = 0;
  endtask

  task automatic model_cmp(input string tag);
    chk({tag, ".valid"}, run_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk({tag, ".len"}, run_len, m_q[0].len);
      chk({tag, ".sat"}, run_sat, m_q[0].sat);
    end
    chk({tag, ".ovf"},  overflow,   m_ovf);
    chk({tag, ".drop"}, drop_cnt,   m_drop);
    chk({tag, ".perr"}, proto_err,  m_perr);
    chk({tag, ".tot"},  total_runs, m_tot);
  endtask

  task automatic step(input bit yc, input bit z1, input bit z2, input bit rdy);
    mrec_t r;
    Yc = yc; Z1 = z1; Z2 = z2; run_ready = rdy;
    @(posedge clk);
    if ((z1 && z2) || ((z1 || z2) && !yc)) m_perr = 1;
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (z1) begin
      r.len = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      r.sat = (m_cnt + 1 > 255);
      m_cnt = 0;
      if (m_tot < 65535) m_tot++;
      if (m_q.size() < 2) m_q.push_back(r);
      else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end else if (z2) m_cnt++;
    #1;
    model_cmp("model");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, run_valid, 0);
    chk({tag, ".len"},   run_len, 0);
    chk({tag, ".sat"},   run_sat, 0);
    chk({tag, ".ovf"},   overflow, 0);
    chk({tag, ".drop"},  drop_cnt, 0);
    chk({tag, ".perr"},  proto_err, 0);
    chk({tag, ".tot"},   total_runs, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    #1;
    chk_all_zero("rst");
    for (int i = 0; i < 3; i++) begin
      Yc = $urandom; Z1 = $urandom; Z2 = $urandom; run_ready = $urandom;
      @(posedge clk); #1;
    end
    chk_all_zero("rst_hold");
    reset = 1'b1;
  endtask

  function automatic vec_t mk(bit yc, bit z1, bit z2, bit rdy, bit ev, int elen,
                              int etot, int edrop, bit eovf);
    vec_t v;
    v.yc = yc; v.z1 = z1; v.z2 = z2; v.rdy = rdy; v.ev = ev; v.elen = elen;
    v.esat = 0; v.etot = etot; v.edrop = edrop; v.eovf = eovf;
    return v;
  endfunction

  initial begin
    Yc = 0; Z1 = 0; Z2 = 0; run_ready = 0; reset = 0;
    #3;
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("idle.valid", run_valid, 0);
    chk("idle.tot", total_runs, 0);

    // Run of 4 drained immediately, then runs 2,5,1 with consumer stalled.
    tbl[0]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 1, 1, 4, 1, 0, 0);
    tbl[4]  = mk(1, 0, 0, 1, 0, 0, 1, 0, 0);
    tbl[5]  = mk(1, 0, 1, 0, 0, 0, 1, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, 1, 2, 2, 0, 0);
    tbl[7]  = mk(1, 0, 1, 0, 1, 2, 2, 0, 0);
    tbl[8]  = mk(1, 0, 1, 0, 1, 2, 2, 0, 0);
    tbl[9]  = mk(1, 0, 1, 0, 1, 2, 2, 0, 0);
    tbl[10] = mk(1, 0, 1, 0, 1, 2, 2, 0, 0);
    tbl[11] = mk(1, 1, 0, 0, 1, 2, 3, 0, 0);
    tbl[12] = mk(1, 1, 0, 0, 1, 2, 4, 1, 1);
    tbl[13] = mk(1, 0, 0, 1, 1, 5, 4, 1, 1);
    tbl[14] = mk(1, 0, 0, 1, 0, 0, 4, 1, 1);
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].yc, tbl[i].z1, tbl[i].z2, tbl[i].rdy);
      chk($sformatf("tbl%0d.valid", i), run_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d.len", i), run_len, tbl[i].elen);
        chk($sformatf("tbl%0d.sat", i), run_sat, tbl[i].esat);
      end
      chk($sformatf("tbl%0d.tot", i),  total_runs, tbl[i].etot);
      chk($sformatf("tbl%0d.drop", i), drop_cnt,   tbl[i].edrop);
      chk($sformatf("tbl%0d.ovf", i),  overflow,   tbl[i].eovf);
    end

    // FULL buffer: exit coincides with a pop, so nothing is dropped.
    step(1, 0, 1, 0); step(1, 1, 0, 0);
    step(1, 0, 1, 0); step(1, 0, 1, 0); step(1, 1, 0, 0);
    chk("full.len", run_len, 2);
    step(1, 0, 1, 0);
    step(1, 1, 0, 1);
    chk("fullpp.valid", run_valid, 1);
    chk("fullpp.head", run_len, 3);
    chk("fullpp.drop", drop_cnt, 1);
    step(1, 0, 0, 1);
    chk("fullpp.next", run_len, 2);
    step(1, 0, 0, 1);
    chk("fullpp.empty", run_valid, 0);

    // Saturation: 300 stays then exit; next short run is clean.
    for (int i = 0; i < 300; i++) step(1, 0, 1, 1);
    step(1, 1, 0, 1);
    chk("sat.len", run_len, 255);
    chk("sat.sat", run_sat, 1);
    step(1, 0, 1, 1); step(1, 1, 0, 1);
    chk("sat2.len", run_len, 2);
    chk("sat2.sat", run_sat, 0);

    // Protocol errors and reset in the middle of a run.
    step(1, 0, 0, 1);
    chk("perr.pre", proto_err, 0);
    step(1, 1, 1, 1);
    chk("perr.both", proto_err, 1);
    chk("perr.both.len", run_len, 1);
    do_reset();
    step(0, 0, 1, 1);
    chk("perr.noyc", proto_err, 1);
    step(1, 0, 1, 1); step(1, 0, 1, 1);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    reset = 1'b1;
    step(1, 1, 0, 0);
    chk("postrst.len", run_len, 1);
    chk("postrst.tot", total_runs, 1);
    chk("postrst.perr", proto_err, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 600) == 0) do_reset();
      step(($urandom % 8) != 0, ($urandom % 5) == 0, ($urandom % 3) != 0,
           ($urandom % 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
